// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//   Multi-ported architectural register file with an integrated scoreboard.
//   Each register carries a busy bit that marks it as awaiting a pending
//   producer. A register turns busy on alloc and clears when written back.
//   Register 0 is hard-wired to zero and is never busy.
//   Reads are combinational and bypass same-cycle writes. The highest-index
//   write port wins when two ports target one register.
//
// Ports
//   clk        in   single clock, rising-edge state updates
//   rst_n      in   asynchronous active-low reset (data, busy bits, count)
//   rd_addr    in   NRD*AW    read addresses, port i at [i*AW +: AW]
//   rd_data    out  NRD*XLEN  read data per port (bypassed, combinational)
//   rd_busy    out  NRD       addressed register awaits a pending write
//   wr_en      in   NWR       write enable per port
//   wr_addr    in   NWR*AW    write address per port
//   wr_data    in   NWR*XLEN  write data per port
//   alloc_en   in   1         mark alloc_addr as having a pending producer
//   alloc_addr in   AW        register to mark busy
//   flush      in   1         clear every busy bit
//   busy_cnt   out  CW        registered number of set busy bits
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    localparam int AW  = $clog2(NREG),
    localparam int CW  = $clog2(NREG + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 alloc_en,
    input  logic [AW-1:0]        alloc_addr,
    input  logic                 flush,
    output logic [CW-1:0]        busy_cnt
);

    // Architectural state
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [CW-1:0]   busy_cnt_q;

    // Unpacked views of the flattened port buses
    logic [AW-1:0]   ra [NRD];
    logic [AW-1:0]   wa [NWR];
    logic [XLEN-1:0] wd [NWR];

    // Per-read-port bypass result
    logic [NRD-1:0]  rd_hit;
    logic [XLEN-1:0] rd_val [NRD];

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_unpack
        assign ra[gi] = rd_addr[gi*AW +: AW];
    end

    for (genvar gj = 0; gj < NWR; gj++) begin : g_wr_unpack
        assign wa[gj] = wr_addr[gj*AW +: AW];
        assign wd[gj] = wr_data[gj*XLEN +: XLEN];
    end

    // Number of set bits in a busy vector
    function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < NREG; k++) begin
            c = c + CW'(v[k]);
        end
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // Next-state: writes, then alloc, then flush.
    // Ports are visited in ascending order, so the highest-index port is
    // applied last and wins a same-address collision. Alloc is applied after
    // the writeback clear, so a new producer keeps the register busy even
    // when the old producer writes back in the same cycle. Flush overrides
    // both writes and alloc for busy bits only; data writes still land.
    // -------------------------------------------------------------------------
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
        end
        busy_d = busy_q;

        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wa[j] != '0)) begin
                regs_d[wa[j]] = wd[j];
                busy_d[wa[j]] = 1'b0;
            end
        end

        if (alloc_en && (alloc_addr != '0)) begin
            busy_d[alloc_addr] = 1'b1;
        end

        if (flush) begin
            busy_d = '0;
        end

        // x0 is constant zero and never tracked
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    // -------------------------------------------------------------------------
    // Read path with write bypass.
    // A same-cycle write makes the value available now, so a register that is
    // being written back must not report busy on this cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_hit  = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_val[i] = regs_q[ra[i]];
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wa[j] == ra[i])) begin
                    rd_hit[i] = 1'b1;
                    rd_val[i] = wd[j];
                end
            end
            if (ra[i] == '0) begin
                rd_hit[i] = 1'b0;
                rd_val[i] = '0;
            end
            rd_data[i*XLEN +: XLEN] = rd_val[i];
            rd_busy[i] = (ra[i] != '0) && busy_q[ra[i]] && !rd_hit[i];
        end
    end

    // -------------------------------------------------------------------------
    // State registers.
    // busy_cnt follows the busy vector written on the same edge, so it always
    // matches the busy bits currently held.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= popcount(busy_d);
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;
    localparam int CW   = 6;

    // Output selectors used by the scoreboard
    localparam int S_RD0   = 0;
    localparam int S_RD1   = 1;
    localparam int S_BUSY0 = 2;
    localparam int S_BUSY1 = 3;
    localparam int S_CNT   = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic                flush;
    logic [CW-1:0]       busy_cnt;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .busy_cnt   (busy_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        int          src;
        logic [63:0] exp;
    } exp_t;

    exp_t sb_q[$];

    // Reference state
    logic [XLEN-1:0] m_regs [NREG];
    logic            m_busy [NREG];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] observed(input int src);
        case (src)
            S_RD0:   return 64'(rd_data[0 +: XLEN]);
            S_RD1:   return 64'(rd_data[XLEN +: XLEN]);
            S_BUSY0: return 64'(rd_busy[0]);
            S_BUSY1: return 64'(rd_busy[1]);
            default: return 64'(busy_cnt);
        endcase
    endfunction

    task automatic push(input string tag, input int src, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.src = src;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observed(e.src), e.exp);
        end
    endtask

    task automatic idle();
        rd_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        flush      = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
        wr_en[p]                = 1'b1;
        wr_addr[p*AW +: AW]     = AW'(a);
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_alloc(input int a);
        alloc_en   = 1'b1;
        alloc_addr = AW'(a);
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    function automatic int model_cnt();
        int c;
        c = 0;
        for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    // Expected combinational outputs for the inputs currently driven
    task automatic predict();
        int              a;
        logic            hit;
        logic [XLEN-1:0] v;
        for (int i = 0; i < NRD; i++) begin
            a   = int'(rd_addr[i*AW +: AW]);
            hit = 1'b0;
            v   = m_regs[a];
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
                    hit = 1'b1;
                    v   = wr_data[j*XLEN +: XLEN];
                end
            end
            if (a == 0) begin
                hit = 1'b0;
                v   = '0;
            end
            push($sformatf("model_rd_data%0d_x%0d", i, a), S_RD0 + i, 64'(v));
            push($sformatf("model_rd_busy%0d_x%0d", i, a), S_BUSY0 + i,
                 64'((a != 0) && m_busy[a] && !hit));
        end
        push("model_busy_cnt", S_CNT, 64'(model_cnt()));
    endtask

    // Reference state update for one rising edge
    task automatic update();
        int a;
        for (int j = 0; j < NWR; j++) begin
            a = int'(wr_addr[j*AW +: AW]);
            if (wr_en[j] && a != 0) begin
                m_regs[a] = wr_data[j*XLEN +: XLEN];
                m_busy[a] = 1'b0;
            end
        end
        a = int'(alloc_addr);
        if (alloc_en && a != 0) m_busy[a] = 1'b1;
        if (flush) begin
            for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
        end
    endtask

    // One clock cycle: inputs already driven; check mid-cycle, then clock
    task automatic cycle();
        #2;
        predict();
        drain();
        @(posedge clk);
        if (rst_n) update();
        #1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();

        // Reset state, checked before any clock edge
        set_rd(0, 5);
        set_rd(1, 31);
        #2;
        push("reset_rd0", S_RD0, 64'h0);
        push("reset_rd1", S_RD1, 64'h0);
        push("reset_busy0", S_BUSY0, 64'h0);
        push("reset_cnt", S_CNT, 64'h0);
        drain();
        // Write and alloc held during reset edges must be discarded
        set_wr(0, 5, 32'hCAFE);
        set_alloc(5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_rd(0, 5);
        push("reset_discard_data", S_RD0, 64'h0);
        push("reset_discard_busy", S_BUSY0, 64'h0);
        cycle();

        // Write x5 via port 0, read via port 1 next cycle
        set_wr(0, 5, 32'hDEADBEEF);
        cycle();
        set_rd(1, 5);
        push("x5_rd1", S_RD1, 64'hDEADBEEF);
        push("x5_busy1", S_BUSY1, 64'h0);
        cycle();

        // Same-address collision: port 1 wins, bypass and storage
        set_wr(0, 7, 32'h11);
        set_wr(1, 7, 32'h22);
        set_rd(0, 7);
        push("x7_bypass", S_RD0, 64'h22);
        cycle();
        set_rd(0, 7);
        push("x7_stored", S_RD0, 64'h22);
        cycle();

        // Alloc, busy read, writeback bypass, count drop
        set_alloc(3);
        cycle();
        set_rd(0, 3);
        push("x3_busy", S_BUSY0, 64'h1);
        push("x3_cnt1", S_CNT, 64'h1);
        cycle();
        set_wr(0, 3, 32'h55);
        set_rd(0, 3);
        push("x3_wb_busy", S_BUSY0, 64'h0);
        push("x3_wb_data", S_RD0, 64'h55);
        cycle();
        push("x3_cnt0", S_CNT, 64'h0);
        cycle();

        // Alloc and write the same register together
        set_alloc(9);
        set_wr(1, 9, 32'h1);
        cycle();
        set_rd(0, 9);
        push("x9_busy", S_BUSY0, 64'h1);
        push("x9_data", S_RD0, 64'h1);
        push("x9_cnt", S_CNT, 64'h1);
        cycle();

        // Re-alloc of a busy register leaves the count unchanged
        set_alloc(9);
        cycle();
        push("x9_realloc_cnt", S_CNT, 64'h1);
        cycle();

        // Fill busy bits, then flush with a simultaneous alloc
        set_alloc(1);
        cycle();
        set_alloc(2);
        cycle();
        set_alloc(3);
        cycle();
        push("pre_flush_cnt", S_CNT, 64'h4);
        flush = 1'b1;
        set_alloc(4);
        cycle();
        set_rd(0, 4);
        set_rd(1, 3);
        push("flush_cnt", S_CNT, 64'h0);
        push("flush_x4_busy", S_BUSY0, 64'h0);
        push("flush_x3_busy", S_BUSY1, 64'h0);
        push("flush_x3_data", S_RD1, 64'h55);
        cycle();
        set_rd(0, 9);
        set_rd(1, 5);
        push("flush_x9_data", S_RD0, 64'h1);
        push("flush_x5_data", S_RD1, 64'hDEADBEEF);
        cycle();

        // Flush does not block a same-cycle write
        flush = 1'b1;
        set_wr(0, 10, 32'hA5A5);
        cycle();
        set_rd(0, 10);
        push("flush_write_x10", S_RD0, 64'hA5A5);
        cycle();

        // Register 0 ignores writes and allocs
        set_wr(0, 0, 32'hFFFF);
        set_alloc(0);
        set_rd(1, 0);
        push("x0_bypass", S_RD1, 64'h0);
        push("x0_busy_now", S_BUSY1, 64'h0);
        cycle();
        set_rd(0, 0);
        push("x0_data", S_RD0, 64'h0);
        push("x0_busy", S_BUSY0, 64'h0);
        push("x0_cnt", S_CNT, 64'h0);
        cycle();

        // Asynchronous reset with x6 busy and traffic in flight
        set_alloc(6);
        cycle();
        set_rd(0, 6);
        push("x6_busy_pre", S_BUSY0, 64'h1);
        push("x6_cnt_pre", S_CNT, 64'h1);
        cycle();
        set_wr(0, 12, 32'hABCD);
        set_alloc(13);
        set_rd(0, 6);
        set_rd(1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        push("async_rst_x6_busy", S_BUSY0, 64'h0);
        push("async_rst_x6_data", S_RD0, 64'h0);
        push("async_rst_x3_data", S_RD1, 64'h0);
        push("async_rst_cnt", S_CNT, 64'h0);
        drain();
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_rd(0, 12);
        set_rd(1, 13);
        push("post_rst_x12", S_RD0, 64'h0);
        push("post_rst_x13_busy", S_BUSY1, 64'h0);
        push("post_rst_cnt", S_CNT, 64'h0);
        cycle();
        set_rd(0, 5);
        set_rd(1, 6);
        push("post_rst_x5", S_RD0, 64'h0);
        push("post_rst_x6_busy", S_BUSY1, 64'h0);
        cycle();

        // Randomised traffic on a small address window against the model
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < NWR; j++) begin
                if ($urandom_range(0, 1) == 1) set_wr(j, int'($urandom_range(0, 7)), $urandom);
            end
            if ($urandom_range(0, 1) == 1) set_alloc(int'($urandom_range(0, 7)));
            flush = ($urandom_range(0, 15) == 0);
            set_rd(0, int'($urandom_range(0, 7)));
            set_rd(1, int'($urandom_range(0, 7)));
            cycle();
        end

        // Saturate: every nonzero register busy
        for (int r = 1; r < NREG; r++) begin
            set_alloc(r);
            cycle();
        end
        push("full_cnt", S_CNT, 64'(NREG - 1));
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREG, default 32, number of architectural registers; power of two, at least 2.
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 Derived AW = clog2(NREG); CW = clog2(NREG+1).
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-009 rd_data  out  NRD*XLEN  read data per port, combinational.
REQ-010 rd_busy  out  NRD  the addressed register awaits a pending write, combinational.
REQ-011 wr_en  in  NWR  write enable per port.
REQ-012 wr_addr  in  NWR*AW  write address per port.
REQ-013 wr_data  in  NWR*XLEN  write data per port.
REQ-014 alloc_en  in  1  marks alloc_addr as having a pending producer.
REQ-015 alloc_addr  in  AW  register to mark busy.
REQ-016 flush  in  1  clears all busy bits.
REQ-017 busy_cnt  out  CW  registered count of set busy bits.

Function
REQ-018 Register 0 SHALL read as zero, ignore writes, never become busy, and never report rd_busy.
REQ-019 A write with wr_en[j]=1 and nonzero wr_addr[j] SHALL update that register at the next rising edge.
REQ-020 Same-cycle writes to the same address SHALL resolve with the highest-index port winning.
REQ-021 Bypass: when any enabled write port targets a nonzero rd_addr[i] in the current cycle, rd_data[i] SHALL equal the winning port's wr_data; otherwise it SHALL equal the stored value.
REQ-022 alloc_en=1 with nonzero alloc_addr SHALL set busy[alloc_addr] at the next edge.
REQ-023 An enabled write SHALL clear busy[wr_addr] at the next edge.
REQ-024 Alloc and write to the same register in the same cycle: busy SHALL end set (new producer wins) and the data SHALL still be written.
REQ-025 rd_busy[i] SHALL equal busy[rd_addr[i]] AND NOT (an enabled write targets rd_addr[i] this cycle).
REQ-026 flush=1 SHALL clear every busy bit at the next edge, overriding a same-cycle alloc_en, and SHALL NOT alter register data or block same-cycle writes.
REQ-027 busy_cnt SHALL equal the number of set busy bits after each edge (registered, one cycle after the causing event); its maximum is NREG-1.
REQ-028 An alloc to an already-busy register SHALL leave it busy with no count change; a write to a non-busy register SHALL leave the count unchanged.
REQ-029 Writes and allocs addressing register 0 SHALL be ignored entirely.

Reset
REQ-030 While rst_n=0, all registers, all busy bits and busy_cnt SHALL clear to 0 immediately, regardless of clk.
REQ-031 A write, alloc or flush coincident with reset assertion SHALL be discarded; the first update SHALL occur at the first rising edge after rst_n returns high.
REQ-032 Reset asserted between alloc and writeback SHALL leave no busy bit set.

Verification
REQ-033 Write 0xDEADBEEF to x5 via port 0, then read x5 on port 1 next cycle -> rd_data=0xDEADBEEF, rd_busy=0.
REQ-034 Ports 0 and 1 both write x7 (0x11, 0x22) in the same cycle while rd_addr[0]=7 -> same-cycle rd_data[0]=0x22; stored value 0x22.
REQ-035 alloc x3; next cycle read x3 -> rd_busy=1, busy_cnt=1; write x3=0x55 -> same cycle rd_busy=0 and rd_data=0x55; next cycle busy_cnt=0.
REQ-036 alloc x9 and write x9=0x1 in the same cycle -> x9 remains busy, x9 reads 0x1, busy_cnt=1.
REQ-037 alloc x1, x2 and x3, then flush with a simultaneous alloc of x4 -> all busy bits 0, busy_cnt=0, data unchanged.
REQ-038 Write x0=0xFFFF and alloc x0; assert rst_n=0 mid-operation with x6 busy -> x0 reads 0, never busy; after reset all reads are 0 and busy_cnt=0.
